param_fifo: RTL and testbench
=============================

PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 16, number of storage entries (power of two, >=4).
REQ-003 SHALL have parameter AF_THRESH, default DEPTH-2, occupancy at or above which almost_full asserts (1..DEPTH-1).
REQ-004 SHALL have parameter AE_THRESH, default 2, occupancy at or below which almost_empty asserts (1..DEPTH-1).
REQ-005 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port write_en  input  1  write request.
REQ-008 SHALL have port read_en  input  1  read request.
REQ-009 SHALL have port data_in  input  DATA_W  write data.
REQ-010 SHALL have port data_out  output  DATA_W  read data, registered.
REQ-011 SHALL have port full  output  1  occupancy == DEPTH.
REQ-012 SHALL have port empty  output  1  occupancy == 0.
REQ-013 SHALL have port almost_full  output  1  occupancy >= AF_THRESH.
REQ-014 SHALL have port almost_empty  output  1  occupancy <= AE_THRESH.
REQ-015 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy 0..DEPTH.
REQ-016 SHALL have port overflow  output  1  registered one-cycle pulse, rejected write.
REQ-017 SHALL have port underflow  output  1  registered one-cycle pulse, rejected read.
REQ-018 SHALL have port error  output  1  overflow/underflow indication (see Configuration).

Function
REQ-019 SHALL accept a read when read_en=1 and empty=0.
REQ-020 SHALL accept a write when write_en=1 and (full=0 or a read is accepted in the same cycle).
REQ-021 SHALL, when full and both requests asserted, accept both; count stays DEPTH; no overflow.
REQ-022 SHALL, when empty and both requests asserted, accept only the write; count becomes 1; underflow pulses.
REQ-023 SHALL drive data_out with the head word on the edge following an accepted read (1-cycle latency); data_out SHALL hold its value otherwise.
REQ-024 SHALL never return a word written in the same cycle as the read that empties the FIFO (no bypass).
REQ-025 SHALL keep read/write pointers $clog2(DEPTH) bits wide, wrapping DEPTH-1 -> 0 without gaps.
REQ-026 SHALL update count +1 on write-only, -1 on read-only, unchanged on both or neither; count SHALL never exceed DEPTH or go below 0.
REQ-027 SHALL derive full, empty, almost_full, almost_empty combinationally from registered count.
REQ-028 SHALL pulse overflow one cycle after write_en=1, full=1, read_en=0; the write SHALL be dropped and storage unchanged.
REQ-029 SHALL pulse underflow one cycle after read_en=1 while empty=1; data_out and pointers SHALL be unchanged.
REQ-030 SHALL preserve FIFO order for all data across any number of pointer wraps.

Reset
REQ-031 SHALL, on rst=0 at any time (including mid-transfer), immediately clear pointers and count, set data_out=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, error=0.
REQ-032 SHALL not require storage array contents to be cleared; no accesses accepted while rst=0.
REQ-033 SHALL resume normal operation on the first rising edge after rst deasserts.

Configuration
REQ-034 SHALL, with PARAM_FIFO_ERR_STICKY_EN defined, hold error=1 from the first overflow or underflow pulse until reset.
REQ-035 SHALL, without PARAM_FIFO_ERR_STICKY_EN, drive error = overflow | underflow (one-cycle pulse, same timing).

Verification (DATA_W=8, DEPTH=8, AF_THRESH=6, AE_THRESH=2)
REQ-036 SHALL cover: write 0x01..0x08 -> full=1, count=8, almost_full from count 6; then read 8 -> data_out 0x01..0x08 in order, each 1 cycle after read_en, empty=1.
REQ-037 SHALL cover: full, write 0xAA with read_en=0 -> overflow and error pulse one cycle, count stays 8, later reads return no 0xAA.
REQ-038 SHALL cover: empty, read_en=1 and write_en=1 with 0x55 -> underflow pulse, count=1, next read returns 0x55.
REQ-039 SHALL cover: full, simultaneous read+write 0x99 for 20 cycles -> count stays 8, no flags, output stream in order, pointers wrap.
REQ-040 SHALL cover: reset asserted with count=5 mid-write -> all outputs to reset values asynchronously, first post-reset write/read returns written value.
REQ-041 SHALL cover: build with and without PARAM_FIFO_ERR_STICKY_EN, underflow then 10 idle cycles -> error stays 1 vs error low after one cycle.

Source files
------------

// File: rtl/param_fifo.sv
// Synchronous single-clock FIFO with programmable almost-full/almost-empty thresholds.
// Define PARAM_FIFO_ERR_STICKY_EN to latch error until reset instead of pulsing it.
module param_fifo #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AF_THRESH = DEPTH - 2,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     write_en,
  input  logic                     read_en,
  input  logic [DATA_W-1:0]        data_in,
  output logic [DATA_W-1:0]        data_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     error
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              rd_acc_c;
  logic              wr_acc_c;
  logic              ovf_c;
  logic              udf_c;

  // Status flags are decoded from the registered occupancy.
  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == CW'(0));
  assign almost_full  = (count >= CW'(AF_THRESH));
  assign almost_empty = (count <= CW'(AE_THRESH));

  // A read frees a slot, so a write into a full FIFO is accepted alongside it.
  always_comb begin
    rd_acc_c = read_en && !empty;
    wr_acc_c = write_en && (!full || rd_acc_c);
    ovf_c    = write_en && full && !read_en;
    udf_c    = read_en && empty;
  end

  // Storage is not reset; writes are blocked while reset is held.
  always_ff @(posedge clk) begin
    if (rst && wr_acc_c) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      data_out  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc_c) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_acc_c) begin
        rd_ptr   <= rd_ptr + AW'(1);
        data_out <= mem[rd_ptr];
      end
      case ({wr_acc_c, rd_acc_c})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      overflow  <= ovf_c;
      underflow <= udf_c;
    end
  end

`ifdef PARAM_FIFO_ERR_STICKY_EN
  logic err_q;

  // Latches on the same edge the first overflow/underflow pulse appears.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (ovf_c || udf_c) begin
      err_q <= 1'b1;
    end
  end

  assign error = err_q;
`else
  assign error = overflow | underflow;
`endif

endmodule

// File: tb/tb_param_fifo.sv
// Self-checking bench for param_fifo (DEPTH=8): directed vector table, corner
// sequences and randomized traffic against a queue-based reference model.
module tb_param_fifo;

`ifdef PARAM_FIFO_ERR_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       write_en;
  logic       read_en;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       full, empty, almost_full, almost_empty;
  logic [3:0] count;
  logic       overflow, underflow, error;

  param_fifo #(.DATA_W(8), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .clk(clk), .rst(rst), .write_en(write_en), .read_en(read_en),
    .data_in(data_in), .data_out(data_out), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow), .error(error)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: occupancy is the queue itself.
  logic [7:0] q[$];
  logic [7:0] m_dout;
  bit         m_err;

  typedef struct {
    bit         we;
    bit         re;
    logic [7:0] din;
    logic [3:0] cnt;
    bit         fu;
    bit         em;
    bit         af;
    bit         ae;
    logic [7:0] dout;
    bit         ovf;
    bit         udf;
    bit         err;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_count"}, 32'(count), 32'(0));
    chk({tag, "_empty"}, 32'(empty), 32'(1));
    chk({tag, "_aempty"}, 32'(almost_empty), 32'(1));
    chk({tag, "_full"}, 32'(full), 32'(0));
    chk({tag, "_afull"}, 32'(almost_full), 32'(0));
    chk({tag, "_dout"}, 32'(data_out), 32'(0));
    chk({tag, "_ovf"}, 32'(overflow), 32'(0));
    chk({tag, "_udf"}, 32'(underflow), 32'(0));
    chk({tag, "_err"}, 32'(error), 32'(0));
  endtask

  task automatic model_clear();
    q.delete();
    m_dout = 8'h00;
    m_err  = 1'b0;
  endtask

  // Holds reset across two edges; releases it away from the clock edge.
  task automatic do_reset();
    write_en = 1'b0;
    read_en  = 1'b0;
    data_in  = 8'h00;
    rst      = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst = 1'b1;
  endtask

  // One clock of traffic, checked against the queue model.
  task automatic step(input bit we, input bit re, input logic [7:0] din);
    int n;
    bit rd, wr, ovf, udf, exp_err;
    n   = q.size();
    rd  = re && (n > 0);
    wr  = we && (n < DEPTH || rd);
    ovf = we && (n == DEPTH) && !re;
    udf = re && (n == 0);
    write_en = we;
    read_en  = re;
    data_in  = din;
    @(posedge clk);
    #1;
    if (rd) m_dout = q.pop_front();
    if (wr) q.push_back(din);
    if (ovf || udf) m_err = 1'b1;
    exp_err = STICKY ? m_err : (ovf || udf);
    chk("m_count", 32'(count), 32'(q.size()));
    chk("m_full", 32'(full), 32'(q.size() == DEPTH));
    chk("m_empty", 32'(empty), 32'(q.size() == 0));
    chk("m_afull", 32'(almost_full), 32'(q.size() >= AF));
    chk("m_aempty", 32'(almost_empty), 32'(q.size() <= AE));
    chk("m_dout", 32'(data_out), 32'(m_dout));
    chk("m_ovf", 32'(overflow), 32'(ovf));
    chk("m_udf", 32'(underflow), 32'(udf));
    chk("m_err", 32'(error), 32'(exp_err));
  endtask

  initial begin
    // Directed table: fill, overflow, drain, underflow-with-write, read back.
    for (int i = 0; i < 8; i++) begin
      tbl[i] = '{1'b1, 1'b0, 8'(i + 1), 4'(i + 1), (i == 7), 1'b0,
                 (i + 1 >= AF), (i + 1 <= AE), 8'h00, 1'b0, 1'b0, 1'b0};
    end
    tbl[8] = '{1'b1, 1'b0, 8'hAA, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 8; k++) begin
      tbl[9 + k] = '{1'b0, 1'b1, 8'h00, 4'(7 - k), 1'b0, (k == 7),
                     (7 - k >= AF), (7 - k <= AE), 8'(k + 1), 1'b0, 1'b0, STICKY};
    end
    tbl[17] = '{1'b1, 1'b1, 8'h55, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h08, 1'b0, 1'b1, 1'b1};
    tbl[18] = '{1'b0, 1'b0, 8'h00, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h08, 1'b0, 1'b0, STICKY};
    tbl[19] = '{1'b0, 1'b1, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, STICKY};

    do_reset();
    for (int i = 0; i < 20; i++) begin
      write_en = tbl[i].we;
      read_en  = tbl[i].re;
      data_in  = tbl[i].din;
      @(posedge clk);
      #1;
      chk($sformatf("t%0d_count", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("t%0d_full", i), 32'(full), 32'(tbl[i].fu));
      chk($sformatf("t%0d_empty", i), 32'(empty), 32'(tbl[i].em));
      chk($sformatf("t%0d_afull", i), 32'(almost_full), 32'(tbl[i].af));
      chk($sformatf("t%0d_aempty", i), 32'(almost_empty), 32'(tbl[i].ae));
      chk($sformatf("t%0d_dout", i), 32'(data_out), 32'(tbl[i].dout));
      chk($sformatf("t%0d_ovf", i), 32'(overflow), 32'(tbl[i].ovf));
      chk($sformatf("t%0d_udf", i), 32'(underflow), 32'(tbl[i].udf));
      chk($sformatf("t%0d_err", i), 32'(error), 32'(tbl[i].err));
    end

    // Full FIFO streaming: simultaneous read+write wraps both pointers.
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'h11 * (i + 1)));
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 8'h99);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 8'h00);

    // Underflow followed by idle cycles: error pulse vs sticky hold.
    do_reset();
    step(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 8'h00);

    // Asynchronous reset mid-write with five words stored.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h20 + i));
    write_en = 1'b1;
    data_in  = 8'h77;
    #2;
    rst = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    model_clear();
    @(posedge clk);
    #1;
    chk_reset_vals("held_rst");
    write_en = 1'b0;
    rst      = 1'b1;
    step(1'b1, 1'b0, 8'h3C);
    step(1'b0, 1'b1, 8'h00);
    chk("post_rst_data", 32'(data_out), 32'h3C);

    // Randomized traffic with shifting read/write bias.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int wp, rp;
      case ((i / 250) % 4)
        0:       begin wp = 80; rp = 20; end
        1:       begin wp = 20; rp = 80; end
        2:       begin wp = 50; rp = 50; end
        default: begin wp = 95; rp = 90; end
      endcase
      step(($urandom_range(0, 99) < 32'(wp)), ($urandom_range(0, 99) < 32'(rp)), 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
